qr_acc_wrapper: RTL and testbench

QR_ACC_WRAPPER -- requirements
Module: qr_acc_wrapper

---
 rtl/qracc_pkg.sv | 54 +++++
 rtl/therm_to_bin.sv | 13 +
 rtl/qr_acc_wrapper.sv | 98 +++++++++
 tb/tb_qr_acc_wrapper.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/qracc_pkg.sv
// qracc_pkg: shared types and array sizes for the QR accelerator wrapper and its analog/SRAM interfaces
package qracc_pkg;
  localparam int NUM_ROWS = 128;
  localparam int NUM_COLS = 32;
  localparam int NUM_ADC_BITS = 4;
  localparam int COMP_COUNT = 2**NUM_ADC_BITS - 1;
  localparam int ADDR_W = $clog2(NUM_ROWS);
  typedef enum logic [2:0] {S_IDLE, S_WRITE, S_PRECH, S_SENSE, S_CAPTURE, S_MAC} state_t;
  typedef struct packed {
    logic binary_cfg;
  } qracc_config_t;
  typedef struct packed {
    logic [NUM_ROWS-1:0] psm_vdr_sel;
    logic [NUM_ROWS-1:0] psm_vdr_selb;
    logic [NUM_ROWS-1:0] psm_vss_sel;
    logic [NUM_ROWS-1:0] psm_vss_selb;
    logic [NUM_ROWS-1:0] psm_vrst_sel;
    logic [NUM_ROWS-1:0] psm_vrst_selb;
    logic [NUM_ROWS-1:0] nsm_vdr_sel;
    logic [NUM_ROWS-1:0] nsm_vdr_selb;
    logic [NUM_ROWS-1:0] nsm_vss_sel;
    logic [NUM_ROWS-1:0] nsm_vss_selb;
    logic [NUM_ROWS-1:0] nsm_vrst_sel;
    logic [NUM_ROWS-1:0] nsm_vrst_selb;
    logic [NUM_ROWS-1:0] wl;
    logic                pch;
    logic [NUM_COLS-1:0] wr_data;
    logic                write;
    logic [NUM_COLS-1:0] csel;
    logic                saen;
    logic                nf;
    logic                nfb;
    logic                m2a;
    logic                m2ab;
    logic                r2a;
    logic                r2ab;
    logic                clk;
  } to_analog_t;
  typedef struct packed {
    logic [NUM_COLS-1:0]            sa_out;
    logic [COMP_COUNT*NUM_COLS-1:0] adc_out;
  } from_analog_t;
  typedef struct packed {
    logic              rq_valid_i;
    logic              rq_wr_i;
    logic [ADDR_W-1:0] addr_i;
    logic [NUM_COLS-1:0] wr_data_i;
  } to_sram_t;
  typedef struct packed {
    logic                rq_ready_o;
    logic                rd_valid_o;
    logic [NUM_COLS-1:0] rd_data_o;
  } from_sram_t;
endpackage

// File: rtl/therm_to_bin.sv
// therm_to_bin: popcount of one column's comparator outputs (therm in, count out); bubbles are simply counted
module therm_to_bin #(
  parameter int numAdcBits = 4,
  parameter int compCount = 2**numAdcBits - 1
) (
  input  logic [compCount-1:0]  therm,
  output logic [numAdcBits-1:0] count
);
  always_comb begin
    count = '0;
    for (int i = 0; i < compCount; i++) count = count + numAdcBits'(therm[i]);
  end
endmodule

// File: rtl/qr_acc_wrapper.sv
// qr_acc_wrapper: SRAM access / MAC controller driving the analog array (clk, nrst, cfg, analog and SRAM request buses, per-column ADC results)
module qr_acc_wrapper
  import qracc_pkg::*;
#(
  parameter int numRows = NUM_ROWS,
  parameter int numCols = NUM_COLS,
  parameter int numAdcBits = NUM_ADC_BITS,
  parameter int compCount = 2**numAdcBits - 1
) (
  input  logic                                clk,
  input  logic                                nrst,
  input  qracc_config_t                       cfg,
  output to_analog_t                          to_analog_o,
  input  from_analog_t                        from_analog_i,
  output logic [numCols-1:0][numAdcBits-1:0]  adc_out_o,
  input  logic                                mac_en_i,
  input  logic [numRows-1:0]                  data_p_i,
  input  logic [numRows-1:0]                  data_n_i,
  input  to_sram_t                            to_sram,
  output from_sram_t                          from_sram
);
  localparam logic [numAdcBits-1:0] bias = numAdcBits'(2**(numAdcBits-1));
  state_t state, state_nxt;
  logic [ADDR_W-1:0] addr_q;
  logic [NUM_COLS-1:0] data_q, rd_data_q;
  logic [numCols-1:0][numAdcBits-1:0] cnt;
  logic accept, mac, binary;
  assign mac = state == S_MAC;
  assign binary = cfg.binary_cfg;
  // a pending MAC request blocks new SRAM requests while idle
  assign accept = state == S_IDLE && !mac_en_i && to_sram.rq_valid_i;
  for (genvar c = 0; c < numCols; c++) begin : g_col
    therm_to_bin #(.numAdcBits(numAdcBits), .compCount(compCount)) u_t2b (
      .therm(from_analog_i.adc_out[c*compCount +: compCount]),
      .count(cnt[c])
    );
  end
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  state_nxt = mac_en_i ? S_MAC : accept ? (to_sram.rq_wr_i ? S_WRITE : S_PRECH) : S_IDLE;
      S_PRECH: state_nxt = S_SENSE;
      S_SENSE: state_nxt = S_CAPTURE;
      S_MAC:   state_nxt = mac_en_i ? S_MAC : S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (nrst) begin
      state <= S_IDLE;
      addr_q <= '0;
      data_q <= '0;
      rd_data_q <= '0;
      adc_out_o <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        addr_q <= to_sram.addr_i;
        data_q <= to_sram.wr_data_i;
      end
      // sense amps are sampled while SAEN is high so the data is presented during CAPTURE
      if (state == S_SENSE) rd_data_q <= from_analog_i.sa_out;
      if (mac)
        for (int i = 0; i < numCols; i++) adc_out_o[i] <= binary ? cnt[i] : cnt[i] - bias;
    end
  end
  assign from_sram.rq_ready_o = state == S_IDLE && !mac_en_i;
  assign from_sram.rd_valid_o = state == S_CAPTURE;
  assign from_sram.rd_data_o = rd_data_q;
  always_comb begin
    to_analog_o = '0;
    to_analog_o.psm_vdr_sel = mac ? data_p_i : '0;
    to_analog_o.psm_vss_sel = mac ? ~data_p_i : '0;
    to_analog_o.nsm_vdr_sel = mac && !binary ? data_n_i : '0;
    to_analog_o.nsm_vss_sel = mac ? (binary ? '1 : ~data_n_i) : '0;
    to_analog_o.psm_vrst_sel = mac ? '0 : '1;
    to_analog_o.nsm_vrst_sel = mac ? '0 : '1;
    to_analog_o.psm_vdr_selb = ~to_analog_o.psm_vdr_sel;
    to_analog_o.psm_vss_selb = ~to_analog_o.psm_vss_sel;
    to_analog_o.nsm_vdr_selb = ~to_analog_o.nsm_vdr_sel;
    to_analog_o.nsm_vss_selb = ~to_analog_o.nsm_vss_sel;
    to_analog_o.psm_vrst_selb = ~to_analog_o.psm_vrst_sel;
    to_analog_o.nsm_vrst_selb = ~to_analog_o.nsm_vrst_sel;
    to_analog_o.wl = state == S_WRITE || state == S_SENSE ? NUM_ROWS'(1) << addr_q : '0;
    to_analog_o.pch = state == S_PRECH;
    to_analog_o.wr_data = state == S_WRITE ? data_q : '0;
    to_analog_o.write = state == S_WRITE;
    to_analog_o.csel = state == S_WRITE ? '1 : '0;
    to_analog_o.saen = state == S_SENSE;
    to_analog_o.nf = !binary;
    to_analog_o.nfb = binary;
    to_analog_o.m2a = mac;
    to_analog_o.m2ab = !mac;
    to_analog_o.r2a = !mac;
    to_analog_o.r2ab = mac;
    to_analog_o.clk = clk;
  end
endmodule

// File: tb/tb_qr_acc_wrapper.sv
// tb_qr_acc_wrapper: directed self-checking bench for qr_acc_wrapper
module tb_qr_acc_wrapper;
  import qracc_pkg::*;
  logic clk = 0;
  logic nrst;
  qracc_config_t cfg;
  to_analog_t ta;
  from_analog_t fa;
  logic [NUM_COLS-1:0][NUM_ADC_BITS-1:0] adc;
  logic mac_en;
  logic [NUM_ROWS-1:0] dp, dn, exp_wl;
  to_sram_t rq;
  from_sram_t rs;
  int vec = 0, errs = 0;

  qr_acc_wrapper dut (
    .clk(clk), .nrst(nrst), .cfg(cfg), .to_analog_o(ta), .from_analog_i(fa),
    .adc_out_o(adc), .mac_en_i(mac_en), .data_p_i(dp), .data_n_i(dn),
    .to_sram(rq), .from_sram(rs)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic test_reset();
    nrst = 1;
    tick();
    tick();
    vec++; if (rs.rq_ready_o !== 1'b1) begin errs++; $display("FAIL reset_ready: got %b expected 1", rs.rq_ready_o); end
    vec++; if (rs.rd_valid_o !== 1'b0) begin errs++; $display("FAIL reset_rd_valid: got %b expected 0", rs.rd_valid_o); end
    vec++; if (rs.rd_data_o !== 32'h0) begin errs++; $display("FAIL reset_rd_data: got %h expected 0", rs.rd_data_o); end
    vec++; if (adc !== '0) begin errs++; $display("FAIL reset_adc: got %h expected 0", adc); end
    vec++; if (ta.psm_vrst_sel !== '1 || ta.nsm_vrst_sel !== '1) begin errs++; $display("FAIL reset_vrst: got %h/%h expected all ones", ta.psm_vrst_sel, ta.nsm_vrst_sel); end
    vec++; if ({ta.m2a, ta.r2a, ta.wl != 0} !== 3'b010) begin errs++; $display("FAIL reset_mux: got m2a=%b r2a=%b wl=%h expected 0/1/0", ta.m2a, ta.r2a, ta.wl); end
    nrst = 0;
    tick();
  endtask

  task automatic test_write();
    exp_wl = '0;
    exp_wl[5] = 1'b1;
    rq.rq_valid_i = 1; rq.rq_wr_i = 1; rq.addr_i = 7'd5; rq.wr_data_i = 32'hA5A5A5A5;
    tick();
    rq.rq_valid_i = 0; rq.wr_data_i = 32'h0;
    #1;
    vec++; if (ta.wl !== exp_wl) begin errs++; $display("FAIL wr_wl: got %h expected %h", ta.wl, exp_wl); end
    vec++; if (ta.write !== 1'b1) begin errs++; $display("FAIL wr_write: got %b expected 1", ta.write); end
    vec++; if (ta.wr_data !== 32'hA5A5A5A5) begin errs++; $display("FAIL wr_data: got %h expected a5a5a5a5", ta.wr_data); end
    vec++; if (ta.csel !== 32'hFFFFFFFF) begin errs++; $display("FAIL wr_csel: got %h expected ffffffff", ta.csel); end
    vec++; if (rs.rq_ready_o !== 1'b0) begin errs++; $display("FAIL wr_busy: got %b expected 0", rs.rq_ready_o); end
    tick();
    vec++; if (rs.rq_ready_o !== 1'b1) begin errs++; $display("FAIL wr_ready_back: got %b expected 1", rs.rq_ready_o); end
    vec++; if (ta.write !== 1'b0 || ta.wl !== '0) begin errs++; $display("FAIL wr_end: got write=%b wl=%h expected 0/0", ta.write, ta.wl); end
  endtask

  task automatic test_read();
    exp_wl = '0;
    exp_wl[5] = 1'b1;
    fa.sa_out = 32'h12345678;
    rq.rq_valid_i = 1; rq.rq_wr_i = 0; rq.addr_i = 7'd5;
    tick();
    rq.rq_valid_i = 0; rq.addr_i = 7'd0;
    #1;
    vec++; if ({ta.pch, ta.saen} !== 2'b10 || ta.wl !== '0) begin errs++; $display("FAIL rd_prech: got pch=%b saen=%b wl=%h expected 1/0/0", ta.pch, ta.saen, ta.wl); end
    tick();
    vec++; if ({ta.pch, ta.saen} !== 2'b01 || ta.wl !== exp_wl) begin errs++; $display("FAIL rd_sense: got pch=%b saen=%b wl=%h expected 0/1/%h", ta.pch, ta.saen, ta.wl, exp_wl); end
    vec++; if (rs.rd_valid_o !== 1'b0) begin errs++; $display("FAIL rd_early_valid: got %b expected 0", rs.rd_valid_o); end
    tick();
    fa.sa_out = 32'hDEADBEEF;
    vec++; if (rs.rd_valid_o !== 1'b1) begin errs++; $display("FAIL rd_valid: got %b expected 1", rs.rd_valid_o); end
    vec++; if (rs.rd_data_o !== 32'h12345678) begin errs++; $display("FAIL rd_data: got %h expected 12345678", rs.rd_data_o); end
    tick();
    vec++; if (rs.rd_valid_o !== 1'b0) begin errs++; $display("FAIL rd_valid_one_cycle: got %b expected 0", rs.rd_valid_o); end
    vec++; if (rs.rd_data_o !== 32'h12345678) begin errs++; $display("FAIL rd_data_hold: got %h expected 12345678", rs.rd_data_o); end
    vec++; if (rs.rq_ready_o !== 1'b1) begin errs++; $display("FAIL rd_ready_back: got %b expected 1", rs.rq_ready_o); end
  endtask

  task automatic test_bipolar_mac();
    cfg.binary_cfg = 0;
    dp = '0; dp[0] = 1'b1;
    dn = '0;
    fa.adc_out = '0;
    fa.adc_out[0 +: 15] = 15'h7FFF;
    mac_en = 1;
    tick();
    vec++; if (rs.rq_ready_o !== 1'b0) begin errs++; $display("FAIL mac_ready: got %b expected 0", rs.rq_ready_o); end
    vec++; if (ta.psm_vdr_sel[0] !== 1'b1 || ta.psm_vss_sel[0] !== 1'b0) begin errs++; $display("FAIL mac_psm0: got vdr=%b vss=%b expected 1/0", ta.psm_vdr_sel[0], ta.psm_vss_sel[0]); end
    vec++; if (ta.nsm_vss_sel[0] !== 1'b1 || ta.nsm_vdr_sel[0] !== 1'b0) begin errs++; $display("FAIL mac_nsm0: got vss=%b vdr=%b expected 1/0", ta.nsm_vss_sel[0], ta.nsm_vdr_sel[0]); end
    vec++; if (ta.psm_vss_sel[1] !== 1'b1 || ta.psm_vdr_selb[0] !== 1'b0) begin errs++; $display("FAIL mac_psm1: got vss1=%b vdrb0=%b expected 1/0", ta.psm_vss_sel[1], ta.psm_vdr_selb[0]); end
    vec++; if (ta.psm_vrst_sel !== '0 || ta.nsm_vrst_selb !== '1) begin errs++; $display("FAIL mac_vrst: got %h/%h expected 0/all ones", ta.psm_vrst_sel, ta.nsm_vrst_selb); end
    vec++; if ({ta.m2a, ta.m2ab, ta.r2a, ta.r2ab, ta.nf} !== 5'b10011) begin errs++; $display("FAIL mac_mux: got %b expected 10011", {ta.m2a, ta.m2ab, ta.r2a, ta.r2ab, ta.nf}); end
    vec++; if (adc[0] !== 4'h0) begin errs++; $display("FAIL mac_latency: got %h expected 0", adc[0]); end
    tick();
    vec++; if (adc[0] !== 4'h7) begin errs++; $display("FAIL bip_7fff: got %h expected 7", adc[0]); end
    fa.adc_out[0 +: 15] = 15'h00FF;
    tick();
    vec++; if (adc[0] !== 4'h0) begin errs++; $display("FAIL bip_00ff: got %h expected 0", adc[0]); end
    fa.adc_out[0 +: 15] = 15'h0000;
    fa.adc_out[15 +: 15] = 15'h0003;
    fa.adc_out[30 +: 15] = 15'h5001;
    tick();
    vec++; if (adc[0] !== 4'h8) begin errs++; $display("FAIL bip_zero: got %h expected 8", adc[0]); end
    vec++; if (adc[1] !== 4'hA) begin errs++; $display("FAIL bip_col1: got %h expected a", adc[1]); end
    vec++; if (adc[2] !== 4'hB) begin errs++; $display("FAIL bip_bubble: got %h expected b", adc[2]); end
  endtask

  task automatic test_binary_mac();
    cfg.binary_cfg = 1;
    dn = '1;
    fa.adc_out[0 +: 15] = 15'h7FFF;
    #1;
    vec++; if (ta.nsm_vss_sel !== '1 || ta.nsm_vdr_sel !== '0) begin errs++; $display("FAIL bin_nsm: got vss=%h vdr=%h expected all ones/0", ta.nsm_vss_sel, ta.nsm_vdr_sel); end
    vec++; if ({ta.nf, ta.nfb} !== 2'b01) begin errs++; $display("FAIL bin_nf: got %b expected 01", {ta.nf, ta.nfb}); end
    tick();
    vec++; if (adc[0] !== 4'hF) begin errs++; $display("FAIL bin_7fff: got %h expected f", adc[0]); end
    vec++; if (adc[1] !== 4'h2) begin errs++; $display("FAIL bin_col1: got %h expected 2", adc[1]); end
    mac_en = 0;
    tick();
    fa.adc_out[0 +: 15] = 15'h0001;
    vec++; if (ta.psm_vrst_sel !== '1 || ta.nsm_vrst_sel !== '1) begin errs++; $display("FAIL idle_vrst: got %h/%h expected all ones", ta.psm_vrst_sel, ta.nsm_vrst_sel); end
    vec++; if (ta.psm_vdr_sel !== '0 || ta.nsm_vss_sel !== '0) begin errs++; $display("FAIL idle_sel: got %h/%h expected 0", ta.psm_vdr_sel, ta.nsm_vss_sel); end
    vec++; if ({ta.m2a, ta.r2a, rs.rq_ready_o} !== 3'b011) begin errs++; $display("FAIL idle_mux: got %b expected 011", {ta.m2a, ta.r2a, rs.rq_ready_o}); end
    tick();
    vec++; if (adc[0] !== 4'hF) begin errs++; $display("FAIL adc_hold: got %h expected f", adc[0]); end
  endtask

  task automatic test_back_to_back();
    cfg.binary_cfg = 0;
    rq.rq_valid_i = 1; rq.rq_wr_i = 1; rq.addr_i = 7'd9; rq.wr_data_i = 32'h0F0F0F0F;
    tick();
    rq.rq_valid_i = 0;
    mac_en = 1;
    #1;
    vec++; if (ta.write !== 1'b1 || ta.m2a !== 1'b0) begin errs++; $display("FAIL b2b_write: got write=%b m2a=%b expected 1/0", ta.write, ta.m2a); end
    tick();
    vec++; if ({ta.write, ta.m2a, rs.rq_ready_o} !== 3'b000) begin errs++; $display("FAIL b2b_idle: got %b expected 000", {ta.write, ta.m2a, rs.rq_ready_o}); end
    tick();
    vec++; if (ta.m2a !== 1'b1) begin errs++; $display("FAIL b2b_mac: got %b expected 1", ta.m2a); end
    mac_en = 0;
    tick();
  endtask

  task automatic test_reset_mid_read();
    bit seen;
    fa.sa_out = 32'hCAFEF00D;
    rq.rq_valid_i = 1; rq.rq_wr_i = 0; rq.addr_i = 7'd3;
    tick();
    rq.rq_valid_i = 0;
    tick();
    nrst = 1;
    tick();
    nrst = 0;
    vec++; if ({rs.rd_valid_o, ta.pch, ta.saen} !== 3'b000) begin errs++; $display("FAIL rst_mid_idle: got %b expected 000", {rs.rd_valid_o, ta.pch, ta.saen}); end
    vec++; if (rs.rd_data_o !== 32'h0) begin errs++; $display("FAIL rst_mid_data: got %h expected 0", rs.rd_data_o); end
    seen = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      seen |= rs.rd_valid_o | ta.write;
    end
    vec++; if (seen !== 1'b0) begin errs++; $display("FAIL rst_mid_pulse: got %b expected 0", seen); end
    vec++; if (rs.rq_ready_o !== 1'b1) begin errs++; $display("FAIL rst_mid_ready: got %b expected 1", rs.rq_ready_o); end
  endtask

  initial begin
    nrst = 1; cfg = '0; fa = '0; mac_en = 0; dp = '0; dn = '0; rq = '0;
    test_reset();
    test_write();
    test_read();
    test_bipolar_mac();
    test_binary_mac();
    test_back_to_back();
    test_reset_mid_read();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule
